gcd_arbiter: RTL and testbench
==============================

GCD_ARBITER -- requirements
Module: gcd_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing one GCD unit; SHALL be a power of two, 2..8.
REQ-002 Parameter WIDTH, default 16: operand and result width.
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req_valid  input  NUM_REQ  per-requester operand-pair valid.
REQ-006 req_data  input  2*WIDTH*NUM_REQ  flattened operand pairs; requester i occupies slice i; within a slice, upper half = hi operand, lower half = lo operand.
REQ-007 req_ready  output  NUM_REQ  per-requester accept, one-hot or zero.
REQ-008 rsp_valid  output  NUM_REQ  per-requester result valid, one-hot or zero.
REQ-009 rsp_data  output  WIDTH  result, shared by all requesters.
REQ-010 rsp_ready  input  NUM_REQ  per-requester result accept.
REQ-011 gcd_in_valid  output  1  operand valid to the GCD unit.
REQ-012 gcd_in_data  output  2*WIDTH  operand pair to the GCD unit, same layout as one req_data slice.
REQ-013 gcd_in_ready  input  1  GCD unit accept.
REQ-014 gcd_out_valid  input  1  GCD result pulse; the GCD unit has no output backpressure.
REQ-015 gcd_out_data  input  WIDTH  GCD result.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 owner  output  log2(NUM_REQ)  index of the requester currently granted.

Function
REQ-018 The FSM SHALL have exactly four states: IDLE, ISSUE, WAIT and RESP.
REQ-019 Only one transaction SHALL be outstanding at a time.
REQ-020 IDLE, arbitration: the winner SHALL be the first asserted req_valid, searching upward from (last_grant+1) mod NUM_REQ with wrap-around.
REQ-021 IDLE, accept: req_ready[winner] SHALL assert combinationally in the same cycle; at the clock edge the block SHALL latch the winner's operands, set owner to the winner and move to ISSUE.
REQ-022 IDLE, no request: with no req_valid asserted, the block SHALL stay in IDLE with req_ready all zero.
REQ-023 req_ready SHALL be zero in ISSUE, WAIT and RESP.
REQ-024 ISSUE: gcd_in_valid SHALL be 1 and gcd_in_data SHALL equal the latched operands, both held stable until gcd_in_ready; the block SHALL move to WAIT on the cycle gcd_in_valid and gcd_in_ready are both high.
REQ-025 WAIT: on gcd_out_valid the block SHALL latch gcd_out_data into the result register and move to RESP.
REQ-026 gcd_out_valid SHALL be ignored in IDLE, ISSUE and RESP.
REQ-027 RESP: rsp_valid[owner] SHALL be 1 and rsp_data SHALL equal the result register.
REQ-028 RESP exit: on rsp_ready[owner] the block SHALL set last_grant to owner and move to IDLE.
REQ-029 rsp_ready on any other requester SHALL be ignored.
REQ-030 Latency: accept to gcd_in_valid SHALL be 1 cycle; gcd_out_valid to rsp_valid SHALL be 1 cycle.
REQ-031 Back-to-back: a new grant SHALL NOT occur in the cycle a response is consumed; the earliest new accept is the following IDLE cycle.
REQ-032 rsp_data SHALL hold its last value outside RESP.
REQ-033 gcd_in_valid SHALL be 0 outside ISSUE.

Reset
REQ-034 While reset is high, state SHALL be IDLE, last_grant SHALL be NUM_REQ-1 (requester 0 wins first), and owner, rsp_data and the latched operands SHALL be 0.
REQ-035 Every output SHALL read 0 from reset assertion without waiting for a clock edge.
REQ-036 Reset asserted in ISSUE, WAIT or RESP SHALL abandon the transaction; no response SHALL be delivered for it.
REQ-037 A late gcd_out_valid after reset SHALL be ignored, per REQ-026.

Configuration
REQ-038 Macro GCD_ARB_ZERO_BYPASS_EN, when defined: an accepted pair with a zero operand SHALL go directly from IDLE to RESP with result = hi if lo==0, lo if hi==0, 0 if both are zero; gcd_in_valid SHALL NOT assert for that pair.
REQ-039 When GCD_ARB_ZERO_BYPASS_EN is undefined, every pair SHALL be forwarded unchanged to the GCD unit; avoiding lo==0 with hi!=0, which never terminates in the GCD unit, is the requester's responsibility.

Verification
REQ-040 Single request: req_valid[0] with hi=0x000C, lo=0x0012 -> gcd_in_data=0x000C0012 one cycle after accept; model returns 6 -> rsp_valid=0001 and rsp_data=0x0006 one cycle later.
REQ-041 Round-robin: all four req_valid held high, each response accepted immediately -> grants 0,1,2,3,0 in that order.
REQ-042 Backpressure: gcd_in_ready low 3 cycles -> gcd_in_valid and gcd_in_data stable; rsp_ready low 5 cycles -> rsp_valid held, req_ready stays 0000.
REQ-043 Zero bypass (macro on): hi=0x0000, lo=0x0015 -> rsp_data=0x0015 one cycle after accept, gcd_in_valid never asserted; macro off -> 0x00000015 is forwarded to the GCD unit.
REQ-044 Reset in WAIT -> all outputs 0 immediately; stray gcd_out_valid afterwards is ignored; next grant goes to requester 0.

Source files
------------

// File: rtl/gcd_arbiter.sv
// Round-robin arbiter that shares one GCD unit among NUM_REQ requesters, one transaction at a time.
// Optional macro GCD_ARB_ZERO_BYPASS_EN answers zero-operand pairs directly, without the GCD unit.
module gcd_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [2*WIDTH*NUM_REQ-1:0]   req_data,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic [NUM_REQ-1:0]           rsp_valid,
  output logic [WIDTH-1:0]             rsp_data,
  input  logic [NUM_REQ-1:0]           rsp_ready,
  output logic                         gcd_in_valid,
  output logic [2*WIDTH-1:0]           gcd_in_data,
  input  logic                         gcd_in_ready,
  input  logic                         gcd_out_valid,
  input  logic [WIDTH-1:0]             gcd_out_data,
  output logic                         busy,
  output logic [$clog2(NUM_REQ)-1:0]   owner
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [IDX_W-1:0]   r_last_grant;
  logic [IDX_W-1:0]   r_owner;
  logic [2*WIDTH-1:0] r_ops;
  logic [WIDTH-1:0]   r_result;

  logic [2*WIDTH-1:0] w_slices [NUM_REQ];
  logic [2*WIDTH-1:0] w_sel;
  logic [IDX_W-1:0]   w_winner;
  logic [IDX_W-1:0]   w_idx;
  logic               w_any;
  logic               w_accept;
  logic               w_bypass;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_slice
      assign w_slices[gi] = req_data[gi*2*WIDTH +: 2*WIDTH];
    end
  endgenerate

  assign w_sel = w_slices[w_winner];

`ifdef GCD_ARB_ZERO_BYPASS_EN
  logic [WIDTH-1:0] w_hi;
  logic [WIDTH-1:0] w_lo;
  assign w_hi     = w_sel[2*WIDTH-1:WIDTH];
  assign w_lo     = w_sel[WIDTH-1:0];
  assign w_bypass = (w_hi == '0) || (w_lo == '0);
`else
  assign w_bypass = 1'b0;
`endif

  // Round-robin search: scanning from farthest to nearest lets the nearest requester after last_grant win.
  always_comb begin
    w_winner = '0;
    w_any    = 1'b0;
    w_idx    = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      w_idx = r_last_grant + IDX_W'(k);
      if (req_valid[w_idx]) begin
        w_winner = w_idx;
        w_any    = 1'b1;
      end else begin
        w_any    = w_any;
      end
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    req_ready    = '0;
    rsp_valid    = '0;
    gcd_in_valid = 1'b0;
    busy         = 1'b1;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (w_any && !reset) begin
          w_accept     = 1'b1;
          req_ready    = ONE_HOT0 << w_winner;
          w_next_state = w_bypass ? S_RESP : S_ISSUE;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_ISSUE: begin
        gcd_in_valid = 1'b1;
        if (gcd_in_ready) begin
          w_next_state = S_WAIT;
        end else begin
          w_next_state = S_ISSUE;
        end
      end
      S_WAIT: begin
        if (gcd_out_valid) begin
          w_next_state = S_RESP;
        end else begin
          w_next_state = S_WAIT;
        end
      end
      S_RESP: begin
        rsp_valid = ONE_HOT0 << r_owner;
        if (rsp_ready[r_owner]) begin
          w_next_state = S_IDLE;
        end else begin
          w_next_state = S_RESP;
        end
      end
      default: begin
        busy         = 1'b0;
        w_next_state = S_IDLE;
      end
    endcase
  end

  // State, grant history, latched operands and result register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_last_grant <= IDX_W'(NUM_REQ - 1);
      r_owner      <= '0;
      r_ops        <= '0;
      r_result     <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        r_owner <= w_winner;
        r_ops   <= w_sel;
      end
      if (r_state == S_WAIT && gcd_out_valid) begin
        r_result <= gcd_out_data;
      end
`ifdef GCD_ARB_ZERO_BYPASS_EN
      else if (w_accept && w_bypass) begin
        r_result <= w_hi | w_lo;
      end
`endif
      if (r_state == S_RESP && rsp_ready[r_owner]) begin
        r_last_grant <= r_owner;
      end
    end
  end

  assign gcd_in_data = r_ops;
  assign rsp_data    = r_result;
  assign owner       = r_owner;

endmodule

// File: tb/tb_gcd_arbiter.sv
// Directed bench for gcd_arbiter: transaction-level model checked every cycle plus literal expectations.
module tb_gcd_arbiter;

  localparam int NREQ = 4;

  logic        clk;
  logic        reset;
  logic [3:0]  req_valid;
  logic [127:0] req_data;
  logic [3:0]  req_ready;
  logic [3:0]  rsp_valid;
  logic [15:0] rsp_data;
  logic [3:0]  rsp_ready;
  logic        gcd_in_valid;
  logic [31:0] gcd_in_data;
  logic        gcd_in_ready;
  logic        gcd_out_valid;
  logic [15:0] gcd_out_data;
  logic        busy;
  logic [1:0]  owner;

  logic        stub_en, stub_ov, stub_pend, man_ov;
  logic [15:0] stub_od, stub_od_n, man_od;
  int          stub_lat, stub_cnt;

  int n_pass = 0;
  int n_total = 0;
  bit cmp_en = 0;
  int grant_q[$];

  gcd_arbiter #(.NUM_REQ(4), .WIDTH(16)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
    .gcd_in_valid(gcd_in_valid), .gcd_in_data(gcd_in_data), .gcd_in_ready(gcd_in_ready),
    .gcd_out_valid(gcd_out_valid), .gcd_out_data(gcd_out_data),
    .busy(busy), .owner(owner)
  );

  assign gcd_out_valid = stub_ov | man_ov;
  assign gcd_out_data  = stub_ov ? stub_od : man_od;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] gcd_fn(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] x, y, t;
    x = a; y = b;
    while (y != 16'd0) begin t = x % y; x = y; y = t; end
    return x;
  endfunction

  function automatic int rr_pick(input int last, input logic [3:0] v);
    for (int k = 1; k <= NREQ; k++) begin
      if (v[(last + k) % NREQ]) return (last + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_rsp(input string nm);
    int c;
    c = 0;
    while (rsp_valid == 4'b0000 && c < 50) begin tick(); c++; end
    chk(nm, 64'(rsp_valid != 4'b0000), 64'd1);
  endtask

  // Reference model: one outstanding transaction tracked as progress flags.
  bit          m_busy = 0, m_sent = 0, m_done = 0;
  int          m_owner = 0, m_last = NREQ - 1, m_pick;
  logic [31:0] m_ops = 32'h0, m_pair;
  logic [15:0] m_res = 16'h0;

  always_comb begin
    m_pick = rr_pick(m_last, req_valid);
    m_pair = 32'h0;
    if (m_pick >= 0) m_pair = req_data[m_pick*32 +: 32];
  end

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy <= 0; m_sent <= 0; m_done <= 0;
      m_owner <= 0; m_last <= NREQ - 1; m_ops <= 32'h0; m_res <= 16'h0;
    end else if (!m_busy) begin
      if (m_pick >= 0) begin
        m_busy <= 1; m_owner <= m_pick; m_ops <= m_pair;
`ifdef GCD_ARB_ZERO_BYPASS_EN
        if (m_pair[31:16] == 16'd0 || m_pair[15:0] == 16'd0) begin
          m_sent <= 1; m_done <= 1;
          m_res <= (m_pair[15:0] == 16'd0) ? m_pair[31:16] : m_pair[15:0];
        end else begin
          m_sent <= 0; m_done <= 0;
        end
`else
        m_sent <= 0; m_done <= 0;
`endif
      end
    end else if (!m_sent) begin
      if (gcd_in_ready) m_sent <= 1;
    end else if (!m_done) begin
      if (gcd_out_valid) begin m_done <= 1; m_res <= gcd_out_data; end
    end else if (rsp_ready[m_owner]) begin
      m_busy <= 0; m_sent <= 0; m_done <= 0; m_last <= m_owner;
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("m_req_ready", req_ready, (!reset && !m_busy && m_pick >= 0) ? (4'b0001 << m_pick) : 4'b0000);
      chk("m_gcd_in_valid", gcd_in_valid, m_busy && !m_sent);
      chk("m_gcd_in_data", gcd_in_data, m_ops);
      chk("m_rsp_valid", rsp_valid, m_done ? (4'b0001 << m_owner) : 4'b0000);
      chk("m_rsp_data", rsp_data, m_res);
      chk("m_busy", busy, m_busy);
      chk("m_owner", owner, 64'(m_owner));
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < NREQ; i++) if (req_ready[i]) grant_q.push_back(i);
  end

  // GCD unit stand-in: computes the result and pulses it stub_lat cycles after the handshake.
  always @(posedge clk) begin
    stub_ov <= 1'b0;
    if (reset) begin
      stub_pend <= 1'b0;
    end else if (stub_en && gcd_in_valid && gcd_in_ready) begin
      stub_pend <= 1'b1; stub_cnt <= stub_lat;
      stub_od_n <= gcd_fn(gcd_in_data[31:16], gcd_in_data[15:0]);
    end else if (stub_pend) begin
      if (stub_cnt == 0) begin stub_ov <= 1'b1; stub_od <= stub_od_n; stub_pend <= 1'b0; end
      else stub_cnt <= stub_cnt - 1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; req_valid = 4'b1111; req_data = 128'h0; rsp_ready = 4'b0000;
    gcd_in_ready = 1'b0; man_ov = 1'b0; man_od = 16'h0; stub_en = 1'b0; stub_lat = 0;
    stub_ov = 1'b0; stub_od = 16'h0; stub_od_n = 16'h0; stub_pend = 1'b0; stub_cnt = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", req_ready, 4'b0000);
    chk("rst_busy", busy, 1'b0);
    chk("rst_owner", owner, 2'd0);
    chk("rst_rsp_data", rsp_data, 16'h0);
    chk("rst_gcd_in_valid", gcd_in_valid, 1'b0);
    cmp_en = 1;
    req_valid = 4'b0000;
    reset = 1'b0;
    tick();

    // Round robin, all requesters asserted, responses consumed immediately.
    for (int i = 0; i < NREQ; i++) req_data[i*32 +: 32] = {16'((i + 1) * 6), 16'((i + 1) * 4)};
    grant_q.delete();
    stub_en = 1'b1; stub_lat = 1; gcd_in_ready = 1'b1; rsp_ready = 4'b1111; req_valid = 4'b1111;
    for (int c = 0; c < 200 && grant_q.size() < 5; c++) tick();
    req_valid = 4'b0000;
    for (int c = 0; c < 50 && busy; c++) tick();
    chk("rr_count", grant_q.size(), 5);
    if (grant_q.size() >= 5) begin
      chk("rr_g0", grant_q[0], 0); chk("rr_g1", grant_q[1], 1); chk("rr_g2", grant_q[2], 2);
      chk("rr_g3", grant_q[3], 3); chk("rr_g4", grant_q[4], 0);
    end
    chk("rr_drain", busy, 1'b0);
    rsp_ready = 4'b0000;
    tick();

    // Backpressure on both the GCD input and the response.
    stub_lat = 0; gcd_in_ready = 1'b0; req_data[32 +: 32] = {16'h0015, 16'h000E}; req_valid = 4'b0010;
    tick();
    req_valid = 4'b1111;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("bp_in_valid", gcd_in_valid, 1'b1);
      chk("bp_in_data", gcd_in_data, 32'h0015000E);
      tick();
    end
    gcd_in_ready = 1'b1;
    wait_rsp("bp_rsp_timeout");
    rsp_ready = 4'b0001;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_rsp_valid", rsp_valid, 4'b0010);
      chk("bp_req_ready", req_ready, 4'b0000);
      chk("bp_rsp_data", rsp_data, 16'h0007);
      tick();
    end
    rsp_ready = 4'b0010; req_valid = 4'b0000;
    tick();
    rsp_ready = 4'b0000;
    tick();

    // Single request with hand-driven GCD result.
    stub_en = 1'b0; req_data[31:0] = 32'h000C0012; req_valid = 4'b0001;
    @(negedge clk);
    chk("one_req_ready", req_ready, 4'b0001);
    tick();
    req_valid = 4'b0000;
    @(negedge clk);
    chk("one_in_valid", gcd_in_valid, 1'b1);
    chk("one_in_data", gcd_in_data, 32'h000C0012);
    tick();
    man_ov = 1'b1; man_od = gcd_fn(16'd12, 16'd18);
    tick();
    man_ov = 1'b0;
    @(negedge clk);
    chk("one_rsp_valid", rsp_valid, 4'b0001);
    chk("one_rsp_data", rsp_data, 16'h0006);
    tick();
    rsp_ready = 4'b0001;
    tick();
    rsp_ready = 4'b0000;
    tick();

    // Zero operand pair.
    stub_en = 1'b1; req_data[31:0] = 32'h00000015; req_valid = 4'b0001;
    @(negedge clk);
    chk("zb_req_ready", req_ready, 4'b0001);
    tick();
    req_valid = 4'b0000;
    @(negedge clk);
`ifdef GCD_ARB_ZERO_BYPASS_EN
    chk("zb_rsp_valid", rsp_valid, 4'b0001);
    chk("zb_rsp_data", rsp_data, 16'h0015);
    chk("zb_in_valid", gcd_in_valid, 1'b0);
`else
    chk("zb_in_valid", gcd_in_valid, 1'b1);
    chk("zb_in_data", gcd_in_data, 32'h00000015);
    wait_rsp("zb_rsp_timeout");
    chk("zb_rsp_data", rsp_data, 16'h0015);
`endif
    tick();
    rsp_ready = 4'b0001;
    tick();
    rsp_ready = 4'b0000;
    tick();

    // Reset while waiting on the GCD unit.
    stub_en = 1'b0; req_data[64 +: 32] = 32'h00300012; req_valid = 4'b0100;
    tick();
    req_valid = 4'b0000;
    tick();
    chk("rw_busy_pre", busy, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk("rw_busy", busy, 1'b0);
    chk("rw_owner", owner, 2'd0);
    chk("rw_rsp_valid", rsp_valid, 4'b0000);
    chk("rw_rsp_data", rsp_data, 16'h0);
    chk("rw_in_valid", gcd_in_valid, 1'b0);
    chk("rw_in_data", gcd_in_data, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    man_ov = 1'b1; man_od = 16'h00AB;
    tick();
    man_ov = 1'b0;
    @(negedge clk);
    chk("rw_stray_rsp", rsp_valid, 4'b0000);
    chk("rw_stray_busy", busy, 1'b0);
    tick();
    req_valid = 4'b1111;
    @(negedge clk);
    chk("rw_next_grant", req_ready, 4'b0001);
    tick();
    req_valid = 4'b0000; stub_en = 1'b1;
    wait_rsp("rw_rsp_timeout");
    rsp_ready = 4'b0001;
    tick();
    rsp_ready = 4'b0000;
    tick();

    cmp_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
